// File: rtl/calc_key_seq_if.sv
// calc_key_seq_if: switch inputs, datapath handshake and display
// outputs of the calculator key sequencer.
interface calc_key_seq_if;
  logic [13:0] PSW;
  logic        CALC_DONE;
  logic [3:0]  RES_DIGIT;
  logic        RES_FIT;
  logic [3:0]  OPA;
  logic [3:0]  OPB;
  logic        OP_SUB;
  logic        CALC_GO;
  logic [1:0]  DISP_MODE;
  logic        ERR;
  logic [2:0]  STATE;

  modport master (
    output PSW, CALC_DONE, RES_DIGIT, RES_FIT,
    input  OPA, OPB, OP_SUB, CALC_GO,
    input  DISP_MODE, ERR, STATE
  );

  modport slave (
    input  PSW, CALC_DONE, RES_DIGIT, RES_FIT,
    output OPA, OPB, OP_SUB, CALC_GO,
    output DISP_MODE, ERR, STATE
  );
endinterface

// File: rtl/calc_key_seq.sv
// calc_key_seq: debounced key decoder and operand/operator sequencer.
// Optional macro CALC_CHAIN_EN: operator key in SHOW chains the result.
module calc_key_seq #(
  parameter int DB_CYCLES    = 4,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  calc_key_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GOT_A  = 3'd1,
    GOT_OP = 3'd2,
    GOT_B  = 3'd3,
    CALC   = 3'd4,
    SHOW   = 3'd5
  } state_t;

  localparam logic [7:0] DB_MAX  = 8'(DB_CYCLES);
  localparam logic [7:0] TMO_MAX = 8'(DONE_TIMEOUT - 1);

  logic [13:0] s1, s2, last, stable;
  logic [7:0]  db_cnt;
  logic [7:0]  tmo;
  logic        accept;
  logic        ev;
  logic [13:0] key;
  logic [3:0]  digit;
  logic        is_dig, is_eq, is_clr;
  logic        is_sub, is_add;
  logic        chain_ok;
  logic [3:0]  chain_val;
  state_t      state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= '1;
      s2     <= '1;
      last   <= '1;
      stable <= '1;
      db_cnt <= '0;
    end else begin
      s1   <= bus.PSW;
      s2   <= s1;
      last <= s2;
      if (s2 != last)
        db_cnt <= '0;
      else if (db_cnt != DB_MAX)
        db_cnt <= db_cnt + 8'd1;
      if (accept)
        stable <= s2;
    end
  end

  // new stable vector: counter saturated and vector still unchanged
  assign accept = (db_cnt == DB_MAX) && (s2 == last) && (s2 != stable);
  assign key    = ~s2;
  assign ev     = accept && $onehot(key);
  assign is_dig = |key[9:0];
  assign is_eq  = key[10];
  assign is_clr = key[11];
  assign is_sub = key[12];
  assign is_add = key[13];

  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++)
      if (key[i]) digit = 4'(i);
  end

`ifdef CALC_CHAIN_EN
  assign chain_ok  = bus.RES_FIT;
  assign chain_val = bus.RES_DIGIT;
`else
  logic unused_res;
  assign chain_ok   = 1'b0;
  assign chain_val  = '0;
  assign unused_res = ^{bus.RES_DIGIT, bus.RES_FIT};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bus.OPA       <= '0;
      bus.OPB       <= '0;
      bus.OP_SUB    <= 1'b0;
      bus.CALC_GO   <= 1'b0;
      bus.DISP_MODE <= 2'd0;
      bus.ERR       <= 1'b0;
      tmo           <= '0;
    end else begin
      bus.CALC_GO <= 1'b0;
      if (ev && is_clr) begin
        state         <= IDLE;
        bus.OPA       <= '0;
        bus.OPB       <= '0;
        bus.OP_SUB    <= 1'b0;
        bus.DISP_MODE <= 2'd0;
        bus.ERR       <= 1'b0;
      end else begin
        if (ev)
          bus.ERR <= 1'b0;
        unique case (state)
          IDLE: begin
            if (ev && is_dig) begin
              bus.OPA       <= digit;
              state         <= GOT_A;
              bus.DISP_MODE <= 2'd1;
            end
          end
          GOT_A: begin
            if (ev) begin
              unique case (1'b1)
                is_dig: bus.OPA <= digit;
                is_add, is_sub: begin
                  bus.OP_SUB    <= is_sub;
                  state         <= GOT_OP;
                  bus.DISP_MODE <= 2'd1;
                end
                default: ;
              endcase
            end
          end
          GOT_OP: begin
            if (ev) begin
              unique case (1'b1)
                is_dig: begin
                  bus.OPB       <= digit;
                  state         <= GOT_B;
                  bus.DISP_MODE <= 2'd2;
                end
                is_add, is_sub: bus.OP_SUB <= is_sub;
                default: ;
              endcase
            end
          end
          GOT_B: begin
            if (ev) begin
              unique case (1'b1)
                is_dig: bus.OPB <= digit;
                is_eq: begin
                  state         <= CALC;
                  bus.DISP_MODE <= 2'd2;
                  bus.CALC_GO   <= 1'b1;
                  tmo           <= '0;
                end
                default: ;
              endcase
            end
          end
          CALC: begin
            if (bus.CALC_DONE) begin
              state         <= SHOW;
              bus.DISP_MODE <= 2'd3;
            end else if (tmo == TMO_MAX) begin
              bus.ERR       <= 1'b1;
              state         <= IDLE;
              bus.DISP_MODE <= 2'd0;
            end else begin
              tmo <= tmo + 8'd1;
            end
          end
          SHOW: begin
            if (ev) begin
              unique case (1'b1)
                is_dig: begin
                  bus.OPA       <= digit;
                  bus.OPB       <= '0;
                  state         <= GOT_A;
                  bus.DISP_MODE <= 2'd1;
                end
                is_add, is_sub: begin
                  if (chain_ok) begin
                    bus.OPA       <= chain_val;
                    bus.OP_SUB    <= is_sub;
                    state         <= GOT_OP;
                    bus.DISP_MODE <= 2'd1;
                  end
                end
                default: ;
              endcase
            end
          end
          default: begin
            state         <= IDLE;
            bus.DISP_MODE <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.STATE = state;

endmodule

// File: tb/tb_calc_key_seq.sv
// tb_calc_key_seq: directed key sequences with hand-computed
// expectations for the calculator key sequencer.
module tb_calc_key_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   go_cnt   = 0;
  int   g0;
  int   n;
  bit   stub_en  = 1'b0;

  always #5 clk = ~clk;

  calc_key_seq_if bus();

  calc_key_seq #(
    .DB_CYCLES    (4),
    .DONE_TIMEOUT (16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic press(input int k);
    logic [13:0] v;
    v    = '1;
    v[k] = 1'b0;
    bus.PSW = v;
  endtask

  task automatic hold(input int k, input int c);
    press(k);
    idle(c);
  endtask

  task automatic rel(input int c);
    bus.PSW = '1;
    idle(c);
  endtask

  task automatic tap(input int k);
    hold(k, 10);
    rel(10);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_opa"}, 16'(bus.OPA), 16'd0);
    chk({tag, "_opb"}, 16'(bus.OPB), 16'd0);
    chk({tag, "_sub"}, 16'(bus.OP_SUB), 16'd0);
    chk({tag, "_go"}, 16'(bus.CALC_GO), 16'd0);
    chk({tag, "_disp"}, 16'(bus.DISP_MODE), 16'd0);
    chk({tag, "_err"}, 16'(bus.ERR), 16'd0);
    chk({tag, "_state"}, 16'(bus.STATE), 16'd0);
  endtask

  task automatic wait_calc(input string tag);
    int m;
    m = 0;
    while (bus.STATE !== 3'd4 && m < 20) begin
      idle(1);
      m++;
    end
    chk(tag, 16'(bus.STATE), 16'd4);
  endtask

  // stub datapath: result ready two cycles after the compute strobe
  initial begin
    bus.CALC_DONE = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.CALC_GO === 1'b1) begin
        go_cnt++;
        if (stub_en) begin
          repeat (2) @(negedge clk);
          bus.CALC_DONE = 1'b1;
          @(negedge clk);
          bus.CALC_DONE = 1'b0;
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.PSW       = '1;
    bus.RES_DIGIT = 4'd3;
    bus.RES_FIT   = 1'b0;
    idle(3);
    chk_reset("rst");
    rst = 1'b0;
    idle(2);

    // basic 1 + 2 = with exact key latency
    stub_en = 1'b1;
    g0 = go_cnt;
    press(1);
    idle(7);
    chk("lat_early", 16'(bus.STATE), 16'd0);
    idle(1);
    chk("lat_state", 16'(bus.STATE), 16'd1);
    chk("lat_opa", 16'(bus.OPA), 16'd1);
    chk("lat_disp", 16'(bus.DISP_MODE), 16'd1);
    idle(2);
    rel(10);
    tap(13);
    chk("t1_op_state", 16'(bus.STATE), 16'd2);
    chk("t1_op_disp", 16'(bus.DISP_MODE), 16'd1);
    tap(2);
    chk("t1_b_state", 16'(bus.STATE), 16'd3);
    chk("t1_b_disp", 16'(bus.DISP_MODE), 16'd2);
    tap(10);
    chk("t1_opa", 16'(bus.OPA), 16'd1);
    chk("t1_opb", 16'(bus.OPB), 16'd2);
    chk("t1_sub", 16'(bus.OP_SUB), 16'd0);
    chk("t1_go", 16'(go_cnt - g0), 16'd1);
    chk("t1_state", 16'(bus.STATE), 16'd5);
    chk("t1_disp", 16'(bus.DISP_MODE), 16'd3);

    // 6 - 6 = with direct key-to-key changes, starting from SHOW
    g0 = go_cnt;
    hold(6, 10);
    chk("t2_a_state", 16'(bus.STATE), 16'd1);
    chk("t2_a_opb", 16'(bus.OPB), 16'd0);
    hold(12, 10);
    chk("t2_op_sub", 16'(bus.OP_SUB), 16'd1);
    hold(6, 10);
    chk("t2_b_opb", 16'(bus.OPB), 16'd6);
    hold(10, 10);
    rel(10);
    chk("t2_opa", 16'(bus.OPA), 16'd6);
    chk("t2_opb", 16'(bus.OPB), 16'd6);
    chk("t2_sub", 16'(bus.OP_SUB), 16'd1);
    chk("t2_go", 16'(go_cnt - g0), 16'd1);
    chk("t2_state", 16'(bus.STATE), 16'd5);

    // operator in SHOW: result not a single digit
    bus.RES_FIT = 1'b0;
    tap(13);
    chk("nofit_state", 16'(bus.STATE), 16'd5);
    chk("nofit_opa", 16'(bus.OPA), 16'd6);
    bus.RES_FIT = 1'b1;
    tap(13);
`ifdef CALC_CHAIN_EN
    chk("chain_state", 16'(bus.STATE), 16'd2);
    chk("chain_opa", 16'(bus.OPA), 16'd3);
    chk("chain_sub", 16'(bus.OP_SUB), 16'd0);
`else
    chk("nochain_state", 16'(bus.STATE), 16'd5);
    chk("nochain_opa", 16'(bus.OPA), 16'd6);
    chk("nochain_sub", 16'(bus.OP_SUB), 16'd1);
`endif
    bus.RES_FIT = 1'b0;

    // clear, then glitch and two-key chord give no events
    tap(11);
    chk_reset("clr1");
    press(3);
    idle(2);
    rel(10);
    bus.PSW    = '1;
    bus.PSW[3] = 1'b0;
    bus.PSW[4] = 1'b0;
    idle(20);
    rel(10);
    chk("t3_state", 16'(bus.STATE), 16'd0);
    chk("t3_opa", 16'(bus.OPA), 16'd0);
    chk("t3_disp", 16'(bus.DISP_MODE), 16'd0);

    // 5 + 9 = with no CALC_DONE: timeout after 16 cycles in CALC
    stub_en = 1'b0;
    tap(5);
    tap(13);
    tap(9);
    chk("t4_b_state", 16'(bus.STATE), 16'd3);
    g0 = go_cnt;
    press(10);
    wait_calc("t4_calc");
    n = 0;
    while (bus.STATE === 3'd4 && n < 40) begin
      idle(1);
      n++;
    end
    chk("t4_calc_cycles", 16'(n), 16'd16);
    chk("t4_err", 16'(bus.ERR), 16'd1);
    chk("t4_state", 16'(bus.STATE), 16'd0);
    chk("t4_disp", 16'(bus.DISP_MODE), 16'd0);
    chk("t4_go", 16'(go_cnt - g0), 16'd1);
    rel(10);
    chk("t4_err_hold", 16'(bus.ERR), 16'd1);
    tap(7);
    chk("t4_err_clr", 16'(bus.ERR), 16'd0);
    chk("t4_opa7", 16'(bus.OPA), 16'd7);
    chk("t4_state7", 16'(bus.STATE), 16'd1);

    // clear in GOT_B, then RST mid-CALC
    tap(12);
    tap(3);
    chk("t5_b_state", 16'(bus.STATE), 16'd3);
    chk("t5_b_opb", 16'(bus.OPB), 16'd3);
    tap(11);
    chk_reset("clr2");
    tap(5);
    tap(13);
    tap(9);
    press(10);
    wait_calc("t5_calc");
    idle(3);
    rst = 1'b1;
    idle(1);
    chk_reset("rst_calc");
    rst = 1'b0;
    rel(12);
    chk("t5_after", 16'(bus.STATE), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
